// File: rtl/mul_req_scheduler_if.sv
// mul_req_scheduler_if: receive strobes, multiplier handshake, TX handshakes and status of the multiplier scheduler.
interface mul_req_scheduler_if #(parameter int DATA_W = 8);
    logic                  uart_rx_valid;
    logic [DATA_W-1:0]     uart_rx_data;
    logic                  spi_rx_valid;
    logic [DATA_W-1:0]     spi_rx_data;
    logic                  mul_start;
    logic [DATA_W-1:0]     mul_a;
    logic [DATA_W-1:0]     mul_b;
    logic                  mul_done;
    logic [2*DATA_W-1:0]   mul_product;
    logic                  uart_tx_ready;
    logic                  uart_tx_start;
    logic [DATA_W-1:0]     uart_tx_data;
    logic                  spi_tx_ready;
    logic                  spi_tx_start;
    logic [DATA_W-1:0]     spi_tx_data;
    logic                  busy;
    logic                  owner_spi;
    logic [1:0]            overrun;

    modport master (
        input  uart_rx_valid, uart_rx_data, spi_rx_valid, spi_rx_data,
        input  mul_done, mul_product, uart_tx_ready, spi_tx_ready,
        output mul_start, mul_a, mul_b, uart_tx_start, uart_tx_data,
        output spi_tx_start, spi_tx_data, busy, owner_spi, overrun
    );

    modport slave (
        output uart_rx_valid, uart_rx_data, spi_rx_valid, spi_rx_data,
        output mul_done, mul_product, uart_tx_ready, spi_tx_ready,
        input  mul_start, mul_a, mul_b, uart_tx_start, uart_tx_data,
        input  spi_tx_start, spi_tx_data, busy, owner_spi, overrun
    );
endinterface

// File: rtl/mul_req_scheduler.sv
// mul_req_scheduler: pairs UART/SPI operand bytes, shares one multiplier round-robin, returns product MSB first.
// MUL_SCHED_TIMEOUT_EN: discard a lone byte A after TIMEOUT_CYC cycles without byte B.
module mul_req_scheduler #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic               clk,
    input logic               reset,
    mul_req_scheduler_if.master bus
);
    typedef enum logic [2:0] {IDLE, MSTART, MWAIT, TXH, TXH_W, TXL, TXL_W} state_t;
    typedef enum logic [1:0] {EMPTY, HAVE_A, FULL} col_t;

    state_t              state;
    col_t                col [2];
    logic [DATA_W-1:0]   op_a [2];
    logic [DATA_W-1:0]   op_b [2];
    logic [DATA_W-1:0]   rx_d [2];
    logic [1:0]          rx_v;
    logic [1:0]          full;
    logic [1:0]          gnt;
    logic                gnt_any;
    logic                gnt_spi;
    logic                last_spi;
    logic                fell;
    logic                own_ready;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   tx_byte;

    always_comb begin
        rx_v      = {bus.spi_rx_valid, bus.uart_rx_valid};
        rx_d[0]   = bus.uart_rx_data;
        rx_d[1]   = bus.spi_rx_data;
        full      = {col[1] == FULL, col[0] == FULL};
        gnt_any   = (state == IDLE) && (|full);
        // On a tie the source not served last wins
        gnt_spi   = full[1] && (!full[0] || !last_spi);
        gnt       = gnt_any ? (gnt_spi ? 2'b10 : 2'b01) : 2'b00;
        own_ready = bus.owner_spi ? bus.spi_tx_ready : bus.uart_tx_ready;
        tx_byte   = (state == TXH) ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
    end

`ifdef MUL_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmr [2];
    logic [1:0]    expired;

    always_comb
        for (int i = 0; i < 2; i++)
            expired[i] = (col[i] == HAVE_A) && (tmr[i] == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            for (int i = 0; i < 2; i++) tmr[i] <= '0;
        else
            for (int i = 0; i < 2; i++)
                tmr[i] <= rx_v[i] ? '0 : (col[i] == HAVE_A ? tmr[i] + 1'b1 : tmr[i]);
`else
    logic [1:0] expired;
    assign expired = 2'b00;
`endif

    // A byte landing in the grant cycle becomes the next A
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                col[i]  <= EMPTY;
                op_a[i] <= '0;
                op_b[i] <= '0;
            end
            bus.overrun <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++)
                if (rx_v[i] && (gnt[i] || col[i] == EMPTY)) begin
                    col[i]  <= HAVE_A;
                    op_a[i] <= rx_d[i];
                end else if (rx_v[i] && col[i] == HAVE_A) begin
                    col[i]  <= FULL;
                    op_b[i] <= rx_d[i];
                end else if (rx_v[i])
                    bus.overrun[i] <= 1'b1;
                else if (gnt[i] || expired[i])
                    col[i] <= EMPTY;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state             <= IDLE;
            last_spi          <= 1'b1;
            fell              <= 1'b0;
            prod              <= '0;
            bus.busy          <= 1'b0;
            bus.owner_spi     <= 1'b0;
            bus.mul_start     <= 1'b0;
            bus.mul_a         <= '0;
            bus.mul_b         <= '0;
            bus.uart_tx_start <= 1'b0;
            bus.uart_tx_data  <= '0;
            bus.spi_tx_start  <= 1'b0;
            bus.spi_tx_data   <= '0;
        end else begin
            bus.mul_start     <= 1'b0;
            bus.uart_tx_start <= 1'b0;
            bus.spi_tx_start  <= 1'b0;
            case (state)
                IDLE:
                    if (gnt_any) begin
                        state         <= MSTART;
                        bus.busy      <= 1'b1;
                        bus.mul_start <= 1'b1;
                        bus.owner_spi <= gnt_spi;
                        last_spi      <= gnt_spi;
                        bus.mul_a     <= gnt_spi ? op_a[1] : op_a[0];
                        bus.mul_b     <= gnt_spi ? op_b[1] : op_b[0];
                    end
                MSTART: state <= MWAIT;
                MWAIT:
                    if (bus.mul_done) begin
                        prod  <= bus.mul_product;
                        state <= TXH;
                    end
                TXH, TXL:
                    if (own_ready) begin
                        state <= (state == TXH) ? TXH_W : TXL_W;
                        if (bus.owner_spi) begin
                            bus.spi_tx_start <= 1'b1;
                            bus.spi_tx_data  <= tx_byte;
                        end else begin
                            bus.uart_tx_start <= 1'b1;
                            bus.uart_tx_data  <= tx_byte;
                        end
                    end
                TXH_W, TXL_W:
                    if (!own_ready)
                        fell <= 1'b1;
                    else if (fell) begin
                        fell     <= 1'b0;
                        state    <= (state == TXH_W) ? TXL : IDLE;
                        bus.busy <= (state == TXH_W);
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_mul_req_scheduler.sv
// tb_mul_req_scheduler: table vectors, directed corner sequences and random traffic against a product/byte-order model.
module tb_mul_req_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mul_req_scheduler_if #(.DATA_W(8)) bus ();
    mul_req_scheduler #(.DATA_W(8), .TIMEOUT_CYC(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {bit spi; logic [7:0] a; logic [7:0] b; logic [15:0] prod;} vec_t;
    vec_t vt [7];

    int checks = 0;
    int failures = 0;
    int u_starts = 0;
    int s_starts = 0;
    int mul_lat_min = 1;
    int mul_lat_max = 4;
    logic [7:0] cap_u [$];
    logic [7:0] cap_s [$];
    logic [7:0] exp_u [$];
    logic [7:0] exp_s [$];
    bit grant_log [$];

    task automatic check(string name, logic [47:0] act, logic [47:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void expect_pair(bit spi, logic [7:0] a, logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        if (spi) begin exp_s.push_back(p[15:8]); exp_s.push_back(p[7:0]); end
        else begin exp_u.push_back(p[15:8]); exp_u.push_back(p[7:0]); end
    endfunction

    function automatic void flush();
        cap_u.delete(); cap_s.delete(); exp_u.delete(); exp_s.delete(); grant_log.delete();
    endfunction

    task automatic send_byte(bit spi, logic [7:0] d);
        @(posedge clk); #1;
        if (spi) begin bus.spi_rx_valid = 1'b1; bus.spi_rx_data = d; end
        else begin bus.uart_rx_valid = 1'b1; bus.uart_rx_data = d; end
        @(posedge clk); #1;
        if (spi) bus.spi_rx_valid = 1'b0; else bus.uart_rx_valid = 1'b0;
    endtask

    task automatic send_pair(bit spi, logic [7:0] a, logic [7:0] b, int gap);
        send_byte(spi, a);
        repeat (gap) @(posedge clk);
        send_byte(spi, b);
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((cap_u.size() < exp_u.size() || cap_s.size() < exp_s.size() || bus.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check({name, "_timeout"}, 48'(n < 3000), 48'd1);
        check({name, "_uart_count"}, 48'(cap_u.size()), 48'(exp_u.size()));
        check({name, "_spi_count"}, 48'(cap_s.size()), 48'(exp_s.size()));
        for (int i = 0; i < exp_u.size() && i < cap_u.size(); i++)
            check($sformatf("%s_uart_byte%0d", name, i), 48'(cap_u[i]), 48'(exp_u[i]));
        for (int i = 0; i < exp_s.size() && i < cap_s.size(); i++)
            check($sformatf("%s_spi_byte%0d", name, i), 48'(cap_s[i]), 48'(exp_s[i]));
        cap_u.delete(); cap_s.delete(); exp_u.delete(); exp_s.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        flush();
    endtask

    // Multiplier: random latency, operands must stay put until done
    initial begin
        logic [7:0] a0, b0;
        bus.mul_done = 1'b0;
        bus.mul_product = '0;
        forever begin
            @(negedge clk);
            if (bus.mul_start && reset) begin
                grant_log.push_back(bus.owner_spi);
                a0 = bus.mul_a;
                b0 = bus.mul_b;
                repeat ($urandom_range(mul_lat_max, mul_lat_min)) begin
                    @(negedge clk);
                    check("mul_operands_stable", 48'({bus.mul_a, bus.mul_b}), 48'({a0, b0}));
                end
                bus.mul_product = 16'(a0) * 16'(b0);
                bus.mul_done = 1'b1;
                @(negedge clk);
                bus.mul_done = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] d;
        bus.uart_tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.uart_tx_start) begin
                d = bus.uart_tx_data;
                cap_u.push_back(d);
                u_starts++;
                bus.uart_tx_ready = 1'b0;
                repeat ($urandom_range(5, 1)) begin
                    @(negedge clk);
                    if (bus.busy) check("uart_tx_data_held", 48'(bus.uart_tx_data), 48'(d));
                end
                bus.uart_tx_ready = 1'b1;
            end
        end
    end

    initial begin
        logic [7:0] d;
        bus.spi_tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.spi_tx_start) begin
                d = bus.spi_tx_data;
                cap_s.push_back(d);
                s_starts++;
                bus.spi_tx_ready = 1'b0;
                repeat ($urandom_range(5, 1)) begin
                    @(negedge clk);
                    if (bus.busy) check("spi_tx_data_held", 48'(bus.spi_tx_data), 48'(d));
                end
                bus.spi_tx_ready = 1'b1;
            end
        end
    end

    initial begin
        int n, su, ss;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data = '0;
        bus.spi_rx_valid = 1'b0;
        bus.spi_rx_data = '0;
        vt[0] = '{1'b0, 8'h0C, 8'h0B, 16'h0084};
        vt[1] = '{1'b1, 8'hFF, 8'hFF, 16'hFE01};
        vt[2] = '{1'b0, 8'h00, 8'h37, 16'h0000};
        vt[3] = '{1'b1, 8'h10, 8'h10, 16'h0100};
        vt[4] = '{1'b0, 8'h80, 8'h02, 16'h0100};
        vt[5] = '{1'b1, 8'h12, 8'h34, 16'h03A8};
        vt[6] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_mul", 48'({bus.mul_start, bus.mul_a, bus.mul_b}), 48'd0);
        check("reset_tx", 48'({bus.uart_tx_start, bus.uart_tx_data, bus.spi_tx_start, bus.spi_tx_data}), 48'd0);
        check("reset_status", 48'({bus.busy, bus.owner_spi, bus.overrun}), 48'd0);
        reset = 1'b1;

        // mul_start two cycles after the strobe that fills the collector
        send_byte(1'b0, 8'h21);
        @(posedge clk); #1;
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data = 8'h03;
        @(negedge clk);
        check("start_lat_c0", 48'(bus.mul_start), 48'd0);
        @(posedge clk); #1;
        bus.uart_rx_valid = 1'b0;
        @(negedge clk);
        check("start_lat_c1", 48'(bus.mul_start), 48'd0);
        @(negedge clk);
        check("start_lat_c2", 48'({bus.mul_start, bus.busy, bus.mul_a, bus.mul_b}), 48'h3_21_03);
        @(negedge clk);
        check("start_lat_c3", 48'(bus.mul_start), 48'd0);
        expect_pair(1'b0, 8'h21, 8'h03);
        drain("start_lat");

        // Table vectors; the other source's TX must stay silent
        foreach (vt[i]) begin
            su = u_starts;
            ss = s_starts;
            send_pair(vt[i].spi, vt[i].a, vt[i].b, i % 3);
            if (vt[i].spi) begin exp_s.push_back(vt[i].prod[15:8]); exp_s.push_back(vt[i].prod[7:0]); end
            else begin exp_u.push_back(vt[i].prod[15:8]); exp_u.push_back(vt[i].prod[7:0]); end
            drain($sformatf("vec%0d", i));
            check($sformatf("vec%0d_owner", i), 48'(bus.owner_spi), 48'(vt[i].spi));
            check($sformatf("vec%0d_idle_port", i), 48'(vt[i].spi ? u_starts - su : s_starts - ss), 48'd0);
        end

        // Tie after reset goes to UART, then alternation follows the last-served pointer
        apply_reset();
        fork
            send_pair(1'b0, 8'h05, 8'h06, 0);
            send_pair(1'b1, 8'h07, 8'h08, 0);
        join
        expect_pair(1'b0, 8'h05, 8'h06);
        expect_pair(1'b1, 8'h07, 8'h08);
        drain("tie1");
        send_pair(1'b0, 8'h02, 8'h09, 1);
        expect_pair(1'b0, 8'h02, 8'h09);
        drain("solo_uart");
        fork
            send_pair(1'b0, 8'h0A, 8'h0B, 0);
            send_pair(1'b1, 8'h0C, 8'h0D, 0);
        join
        expect_pair(1'b0, 8'h0A, 8'h0B);
        expect_pair(1'b1, 8'h0C, 8'h0D);
        drain("tie2");
        check("grant_count", 48'(grant_log.size()), 48'd5);
        if (grant_log.size() == 5)
            check("grant_order", 48'({grant_log[0], grant_log[1], grant_log[2], grant_log[3], grant_log[4]}), 48'b01010);

        // Third extra byte during MWAIT overflows the full collector
        mul_lat_min = 40;
        mul_lat_max = 40;
        send_pair(1'b0, 8'h03, 8'h05, 0);
        n = 0;
        while (!bus.mul_start && n < 100) begin @(negedge clk); n++; end
        check("ovr_start_seen", 48'(n < 100), 48'd1);
        send_byte(1'b0, 8'h07);
        send_byte(1'b0, 8'h09);
        check("ovr_before_drop", 48'(bus.overrun), 48'd0);
        send_byte(1'b0, 8'h0B);
        @(negedge clk);
        check("ovr_set", 48'(bus.overrun), 48'b01);
        mul_lat_min = 1;
        mul_lat_max = 4;
        expect_pair(1'b0, 8'h03, 8'h05);
        expect_pair(1'b0, 8'h07, 8'h09);
        drain("ovr");
        check("ovr_sticky", 48'(bus.overrun), 48'b01);

        // Reset in TXH_W aborts and clears everything
        send_pair(1'b0, 8'h12, 8'h34, 0);
        n = 0;
        while (!bus.uart_tx_start && n < 200) begin @(negedge clk); n++; end
        check("abort_tx_seen", 48'(n < 200), 48'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_outputs", 48'({bus.mul_start, bus.mul_a, bus.mul_b, bus.uart_tx_start, bus.uart_tx_data}), 48'd0);
        check("abort_status", 48'({bus.spi_tx_start, bus.spi_tx_data, bus.busy, bus.owner_spi, bus.overrun}), 48'd0);
        @(negedge clk);
        reset = 1'b1;
        flush();
        su = u_starts;
        ss = s_starts;
        repeat (40) @(negedge clk);
        check("abort_quiet", 48'({bus.busy, 16'(u_starts - su), 16'(s_starts - ss)}), 48'd0);
        send_pair(1'b1, 8'h0F, 8'h11, 2);
        expect_pair(1'b1, 8'h0F, 8'h11);
        drain("after_abort");

`ifdef MUL_SCHED_TIMEOUT_EN
        apply_reset();
        send_byte(1'b0, 8'h05);
        repeat (20) @(posedge clk);
        send_pair(1'b0, 8'h07, 8'h03, 0);
        expect_pair(1'b0, 8'h07, 8'h03);
        drain("timeout");
`endif

        // Random traffic checked against the product model
        apply_reset();
        for (int it = 0; it < 40; it++) begin
            int mode;
            logic [7:0] ua, ub, sa, sb;
            mode = $urandom_range(2, 0);
            ua = 8'($urandom);
            ub = 8'($urandom);
            sa = 8'($urandom);
            sb = 8'($urandom);
            if (mode != 1) expect_pair(1'b0, ua, ub);
            if (mode != 0) expect_pair(1'b1, sa, sb);
            fork
                if (mode != 1) send_pair(1'b0, ua, ub, $urandom_range(3, 0));
                if (mode != 0) send_pair(1'b1, sa, sb, $urandom_range(3, 0));
            join
            drain($sformatf("rand%0d", it));
        end
        check("rand_no_overrun", 48'(bus.overrun), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
